obj_table_responder: RTL and testbench
======================================

OBJ_TABLE_RESPONDER -- requirements
Module: obj_table_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of object entries (at most 128).
REQ-002 SHALL have parameter LANES, default 4, number of parallel read lanes (fixed at 4).
REQ-003 SHALL have port sys_clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port write_valid_in  in  1  write strobe, one entry per cycle.
REQ-006 SHALL have port save_addr_in  in  7  write entry index.
REQ-007 SHALL have ports is_static_in 1, id_bits_in 2, params_in 36, pos_x_in 16, pos_y_in 16, vel_x_in 16, vel_y_in 16, all inputs, forming the write payload.
REQ-008 SHALL have port read_valid_in  in  4  per-lane read strobe.
REQ-009 SHALL have port load_addr_in  in  4x7  per-lane read index.
REQ-010 SHALL have ports is_static_out 4x1, id_bits_out 4x2, params_out 4x36, pos_x_out/pos_y_out/vel_x_out/vel_y_out 4x16 each, all outputs, forming the per-lane read data.
REQ-011 SHALL have port is_valid_out  out  4  per-lane read-data-valid pulse.
REQ-012 SHALL have port ready_out  out  1  high when the table accepts requests.
REQ-013 SHALL have port addr_err_out  out  1  sticky flag, set when any request uses an index >= DEPTH.

Function
REQ-014 SHALL implement states CLEAR and RUN. Reset SHALL enter CLEAR. CLEAR SHALL move to RUN after the last entry is cleared.
REQ-015 In CLEAR, the block SHALL write all-zero to entry k on clear cycle k (k = 0..DEPTH-1), taking DEPTH cycles in total. ready_out SHALL be 0 throughout CLEAR.
REQ-016 During CLEAR, write and read strobes SHALL be ignored, and is_valid_out SHALL stay 0.
REQ-017 In RUN, ready_out SHALL be 1.
REQ-018 In RUN, a write with valid index SHALL commit the 103-bit entry at the end of the strobe cycle.
REQ-019 Read latency SHALL be fixed at 2 cycles: a strobe on lane L at cycle N SHALL give is_valid_out[L]=1 for exactly cycle N+2, with that lane's data.
REQ-020 Lane data outputs SHALL hold their last value until that lane's next valid pulse.
REQ-021 Lanes SHALL be fully independent. Any lanes may read the same index in the same cycle; all SHALL return identical data.
REQ-022 Back-to-back strobes on a lane SHALL be accepted every cycle (throughput 1 per lane per cycle).
REQ-023 Without the bypass option, a read and a write to the same index in the same cycle SHALL return the pre-write data (read-first).
REQ-024 A read issued in any cycle after the write cycle SHALL return the written data.
REQ-025 A write with index >= DEPTH SHALL be dropped.
REQ-026 A read with index >= DEPTH SHALL still pulse is_valid_out, with all-zero data.
REQ-027 Either out-of-range case SHALL set addr_err_out, which SHALL clear only on reset.
REQ-028 Read strobes already in the pipeline when reset asserts SHALL be discarded; no valid pulse SHALL appear after reset.

Reset
REQ-029 On sys_rst_n low, all outputs SHALL go to 0 asynchronously: is_valid_out, all data outputs, ready_out, addr_err_out.
REQ-030 The state SHALL go to CLEAR and the clear counter to 0.
REQ-031 Entry contents SHALL be defined only by the subsequent CLEAR pass.

Configuration
REQ-032 Macro OBJ_TABLE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-033 With OBJ_TABLE_BYPASS_EN defined, a same-cycle, same-index read and write SHALL return the new write payload on every matching lane, still at 2-cycle latency.
REQ-034 Without OBJ_TABLE_BYPASS_EN, the read-first behaviour of REQ-023 SHALL apply, and the forwarding logic SHALL not be synthesized.

Structure
REQ-035 A shared package obj_pkg SHALL hold: the object struct (is_static, id_bits, params, pos_x, pos_y, vel_x, vel_y; 103 bits, fields in that order MSB to LSB), the field widths, OBJ_ADDR_W=7, and the state enum.
REQ-036 Sub-module obj_table_bank SHALL be used: one write port, one read port, 1-cycle registered read. It SHALL be instantiated once per lane, with all copies sharing the write port.

Verification
REQ-037 Reset then idle: ready_out=0 for exactly 128 cycles, then 1; a read of index 5 on lane 0 returns all-zero with is_valid_out=0001 two cycles later.
REQ-038 Write index 3 with pos_x=16'h0120, vel_y=16'hFFE0, then read index 3 on all lanes next cycle: is_valid_out=1111 at +2 cycles, all lanes pos_x=0120, vel_y=FFE0.
REQ-039 Write index 7 with params=36'h1 while lane 2 reads index 7 in the same cycle: lane 2 returns params 0 without the macro, 1 with OBJ_TABLE_BYPASS_EN.
REQ-040 Streaming: lane 1 reads indices 0..7 on consecutive cycles after distinct writes; the 8 valid pulses are consecutive, in order, with matching data.
REQ-041 With DEPTH=8, a write to index 9 and a read of index 12: memory is unchanged, the read returns zeros with a valid pulse, and addr_err_out=1 and stays set.
REQ-042 Strobes on lanes 0 and 3, with sys_rst_n pulsed low one cycle later: no valid pulse, outputs 0, and the CLEAR pass restarts.

Source files
------------

// File: rtl/obj_pkg.sv
// Shared types for the object table: 103-bit entry layout, address width and table FSM states.
package obj_pkg;

  localparam int OBJ_ADDR_W   = 7;
  localparam int OBJ_ID_W     = 2;
  localparam int OBJ_PARAMS_W = 36;
  localparam int OBJ_POS_W    = 16;
  localparam int OBJ_VEL_W    = 16;
  localparam int OBJ_W        = 1 + OBJ_ID_W + OBJ_PARAMS_W + 2 * OBJ_POS_W + 2 * OBJ_VEL_W;

  typedef struct packed {
    logic                           is_static;
    logic        [OBJ_ID_W-1:0]     id_bits;
    logic        [OBJ_PARAMS_W-1:0] params;
    logic signed [OBJ_POS_W-1:0]    pos_x;
    logic signed [OBJ_POS_W-1:0]    pos_y;
    logic signed [OBJ_VEL_W-1:0]    vel_x;
    logic signed [OBJ_VEL_W-1:0]    vel_y;
  } obj_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } tbl_state_t;

  function automatic logic addr_oor(input logic [OBJ_ADDR_W-1:0] a, input int depth);
    return (32'(a) >= 32'(depth));
  endfunction

endpackage

// File: rtl/obj_table_bank.sv
// One copy of the object table: shared write port, one read port with a registered 1-cycle read (read-first).
module obj_table_bank
  import obj_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  obj_t          i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output obj_t          o_rdata
);

  obj_t r_mem [DEPTH];
  obj_t r_rdata;

  // Non-blocking read and write in one block yields old data on a same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/obj_table_responder.sv
// Multi-lane object table: CLEAR pass after reset, then 1 write + LANES reads per cycle at 2-cycle latency.
// Optional same-cycle write-to-read forwarding is enabled by defining OBJ_TABLE_BYPASS_EN.
module obj_table_responder
  import obj_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int LANES = 4
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst_n,
  input  logic                                   write_valid_in,
  input  logic [OBJ_ADDR_W-1:0]                  save_addr_in,
  input  logic                                   is_static_in,
  input  logic [OBJ_ID_W-1:0]                    id_bits_in,
  input  logic [OBJ_PARAMS_W-1:0]                params_in,
  input  logic signed [OBJ_POS_W-1:0]            pos_x_in,
  input  logic signed [OBJ_POS_W-1:0]            pos_y_in,
  input  logic signed [OBJ_VEL_W-1:0]            vel_x_in,
  input  logic signed [OBJ_VEL_W-1:0]            vel_y_in,
  input  logic [LANES-1:0]                       read_valid_in,
  input  logic [LANES-1:0][OBJ_ADDR_W-1:0]       load_addr_in,
  output logic [LANES-1:0]                       is_static_out,
  output logic [LANES-1:0][OBJ_ID_W-1:0]         id_bits_out,
  output logic [LANES-1:0][OBJ_PARAMS_W-1:0]     params_out,
  output logic [LANES-1:0][OBJ_POS_W-1:0]        pos_x_out,
  output logic [LANES-1:0][OBJ_POS_W-1:0]        pos_y_out,
  output logic [LANES-1:0][OBJ_VEL_W-1:0]        vel_x_out,
  output logic [LANES-1:0][OBJ_VEL_W-1:0]        vel_y_out,
  output logic [LANES-1:0]                       is_valid_out,
  output logic                                   ready_out,
  output logic                                   addr_err_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OBJ_ADDR_W-1:0] CLR_LAST = OBJ_ADDR_W'(DEPTH - 1);

  tbl_state_t              r_state;
  logic [OBJ_ADDR_W-1:0]   r_clr_cnt;
  logic                    r_ready;
  logic                    r_addr_err;

  logic                    w_run;
  logic                    w_wr_oor;
  logic                    w_wr_en_p0;
  obj_t                    w_wr_data_p0;
  logic [LANES-1:0]        w_rd_oor_p0;
  logic [LANES-1:0]        w_rd_en_p0;

  logic                    w_bank_we;
  logic [OBJ_ADDR_W-1:0]   w_bank_waddr;
  obj_t                    w_bank_wdata;
  obj_t                    w_bank_rdata [LANES];

  logic [LANES-1:0]        r_vld_p1;
  logic [LANES-1:0]        r_oor_p1;
  obj_t                    w_lane_data_p1 [LANES];

  logic [LANES-1:0]        r_vld_p2;
  obj_t                    r_data_p2 [LANES];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_cnt == CLR_LAST) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + OBJ_ADDR_W'(1);
          end
        end
        ST_RUN:  r_ready <= 1'b1;
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // Stage p0: request qualification; strobes are ignored until the clear pass finishes.
  assign w_run      = (r_state == ST_RUN);
  assign w_wr_oor   = addr_oor(save_addr_in, DEPTH);
  assign w_wr_en_p0 = w_run & write_valid_in & ~w_wr_oor;

  assign w_wr_data_p0.is_static = is_static_in;
  assign w_wr_data_p0.id_bits   = id_bits_in;
  assign w_wr_data_p0.params    = params_in;
  assign w_wr_data_p0.pos_x     = pos_x_in;
  assign w_wr_data_p0.pos_y     = pos_y_in;
  assign w_wr_data_p0.vel_x     = vel_x_in;
  assign w_wr_data_p0.vel_y     = vel_y_in;

  assign w_bank_we    = ~w_run | w_wr_en_p0;
  assign w_bank_waddr = w_run ? save_addr_in : r_clr_cnt;
  assign w_bank_wdata = w_run ? w_wr_data_p0 : '0;

  always_comb begin
    w_rd_oor_p0 = '0;
    w_rd_en_p0  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_rd_oor_p0[l] = addr_oor(load_addr_in[l], DEPTH);
      w_rd_en_p0[l]  = w_run & read_valid_in[l];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_addr_err <= 1'b0;
    end else if (w_run && ((write_valid_in && w_wr_oor) || |(read_valid_in & w_rd_oor_p0))) begin
      r_addr_err <= 1'b1;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_bank
    obj_table_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .i_clk   (sys_clk),
      .i_we    (w_bank_we),
      .i_waddr (w_bank_waddr[AW-1:0]),
      .i_wdata (w_bank_wdata),
      .i_re    (w_rd_en_p0[l] & ~w_rd_oor_p0[l]),
      .i_raddr (load_addr_in[l][AW-1:0]),
      .o_rdata (w_bank_rdata[l])
    );
  end

  // Stage p1: bank read data is available; out-of-range reads are forced to zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vld_p1 <= '0;
      r_oor_p1 <= '0;
    end else begin
      r_vld_p1 <= w_rd_en_p0;
      r_oor_p1 <= w_rd_oor_p0;
    end
  end

`ifdef OBJ_TABLE_BYPASS_EN
  logic [LANES-1:0] r_byp_hit_p1;
  obj_t             r_byp_data_p1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_byp_hit_p1 <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        r_byp_hit_p1[l] <= w_rd_en_p0[l] & w_wr_en_p0 & (load_addr_in[l] == save_addr_in);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr_en_p0) r_byp_data_p1 <= w_wr_data_p0;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_data_p1[l] = w_bank_rdata[l];
      if (r_oor_p1[l])          w_lane_data_p1[l] = '0;
      else if (r_byp_hit_p1[l]) w_lane_data_p1[l] = r_byp_data_p1;
    end
  end
`else
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_data_p1[l] = r_oor_p1[l] ? '0 : w_bank_rdata[l];
    end
  end
`endif

  // Stage p2: output registers; data holds between valid pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vld_p2 <= '0;
      for (int l = 0; l < LANES; l++) r_data_p2[l] <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      for (int l = 0; l < LANES; l++) begin
        if (r_vld_p1[l]) r_data_p2[l] <= w_lane_data_p1[l];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_out
    assign is_static_out[l] = r_data_p2[l].is_static;
    assign id_bits_out[l]   = r_data_p2[l].id_bits;
    assign params_out[l]    = r_data_p2[l].params;
    assign pos_x_out[l]     = r_data_p2[l].pos_x;
    assign pos_y_out[l]     = r_data_p2[l].pos_y;
    assign vel_x_out[l]     = r_data_p2[l].vel_x;
    assign vel_y_out[l]     = r_data_p2[l].vel_y;
  end

  assign is_valid_out = r_vld_p2;
  assign ready_out    = r_ready;
  assign addr_err_out = r_addr_err;

endmodule

// File: tb/tb_obj_table_responder.sv
// Directed bench for obj_table_responder: a DEPTH=128 instance plus a DEPTH=8 instance for range errors.
module tb_obj_table_responder;
  import obj_pkg::*;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              write_valid_in;
  logic [6:0]        save_addr_in;
  logic              is_static_in;
  logic [1:0]        id_bits_in;
  logic [35:0]       params_in;
  logic [15:0]       pos_x_in, pos_y_in, vel_x_in, vel_y_in;
  logic [3:0]        read_valid_in;
  logic [3:0][6:0]   load_addr_in;

  logic [3:0]        m_st, s_st;
  logic [3:0][1:0]   m_id, s_id;
  logic [3:0][35:0]  m_prm, s_prm;
  logic [3:0][15:0]  m_px, m_py, m_vx, m_vy, s_px, s_py, s_vx, s_vy;
  logic [3:0]        m_vld, s_vld;
  logic              m_rdy, s_rdy, m_err, s_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  obj_table_responder #(.DEPTH(128), .LANES(4)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .write_valid_in(write_valid_in), .save_addr_in(save_addr_in),
    .is_static_in(is_static_in), .id_bits_in(id_bits_in), .params_in(params_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
    .read_valid_in(read_valid_in), .load_addr_in(load_addr_in),
    .is_static_out(m_st), .id_bits_out(m_id), .params_out(m_prm),
    .pos_x_out(m_px), .pos_y_out(m_py), .vel_x_out(m_vx), .vel_y_out(m_vy),
    .is_valid_out(m_vld), .ready_out(m_rdy), .addr_err_out(m_err)
  );

  obj_table_responder #(.DEPTH(8), .LANES(4)) u_small (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .write_valid_in(write_valid_in), .save_addr_in(save_addr_in),
    .is_static_in(is_static_in), .id_bits_in(id_bits_in), .params_in(params_in),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .vel_x_in(vel_x_in), .vel_y_in(vel_y_in),
    .read_valid_in(read_valid_in), .load_addr_in(load_addr_in),
    .is_static_out(s_st), .id_bits_out(s_id), .params_out(s_prm),
    .pos_x_out(s_px), .pos_y_out(s_py), .vel_x_out(s_vx), .vel_y_out(s_vy),
    .is_valid_out(s_vld), .ready_out(s_rdy), .addr_err_out(s_err)
  );

  typedef struct {
    logic [6:0] addr;
    obj_t       wdata;
    obj_t       exp;
  } vec_t;

  vec_t tab [8];

  function automatic obj_t m_lane(input int l);
    obj_t o;
    o.is_static = m_st[l]; o.id_bits = m_id[l]; o.params = m_prm[l];
    o.pos_x = m_px[l]; o.pos_y = m_py[l]; o.vel_x = m_vx[l]; o.vel_y = m_vy[l];
    return o;
  endfunction

  function automatic obj_t s_lane(input int l);
    obj_t o;
    o.is_static = s_st[l]; o.id_bits = s_id[l]; o.params = s_prm[l];
    o.pos_x = s_px[l]; o.pos_y = s_py[l]; o.vel_x = s_vx[l]; o.vel_y = s_vy[l];
    return o;
  endfunction

  function automatic obj_t mk(input logic st, input logic [1:0] id, input logic [35:0] prm,
                              input logic [15:0] px, input logic [15:0] py,
                              input logic [15:0] vx, input logic [15:0] vy);
    obj_t o;
    o.is_static = st; o.id_bits = id; o.params = prm;
    o.pos_x = px; o.pos_y = py; o.vel_x = vx; o.vel_y = vy;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_obj(input string nm, input obj_t act, input obj_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %026h expected %026h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle();
    write_valid_in = 1'b0;
    read_valid_in  = 4'b0000;
  endtask

  task automatic set_wr(input logic [6:0] a, input obj_t d);
    write_valid_in = 1'b1;
    save_addr_in   = a;
    is_static_in   = d.is_static;
    id_bits_in     = d.id_bits;
    params_in      = d.params;
    pos_x_in       = d.pos_x;
    pos_y_in       = d.pos_y;
    vel_x_in       = d.vel_x;
    vel_y_in       = d.vel_y;
  endtask

  task automatic set_rd(input logic [3:0] mask, input logic [6:0] a);
    read_valid_in = mask;
    for (int l = 0; l < 4; l++) load_addr_in[l] = a;
  endtask

  // Counts cycles with ready low after reset release; also flags any valid pulse during CLEAR.
  task automatic count_clear(input string nm);
    int cnt;
    int vseen;
    cnt = 0;
    vseen = 0;
    while (!m_rdy && cnt < 300) begin
      if (m_vld != 4'b0000) vseen++;
      cnt++;
      step();
    end
    chk({nm, "_ready_low_cycles"}, 32'(cnt), 32'd128);
    chk({nm, "_valid_in_clear"}, 32'(vseen), 32'd0);
    chk({nm, "_ready_high"}, 32'(m_rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obj_t d;
    logic [35:0] exp_prm;
    idle();
    save_addr_in = '0; is_static_in = 1'b0; id_bits_in = '0; params_in = '0;
    pos_x_in = '0; pos_y_in = '0; vel_x_in = '0; vel_y_in = '0;
    load_addr_in = '0;
    sys_rst_n = 1'b0;

    tab[0] = '{7'd0, mk(1'b0, 2'd1, 36'h000000011, 16'h0001, 16'h0010, 16'h0100, 16'h1000), '0};
    tab[1] = '{7'd1, mk(1'b1, 2'd2, 36'h123456789, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0002), '0};
    tab[2] = '{7'd2, mk(1'b0, 2'd3, 36'hFFFFFFFFF, 16'h0000, 16'h0003, 16'hFFFE, 16'hABCD), '0};
    tab[3] = '{7'd3, mk(1'b1, 2'd0, 36'h800000000, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), '0};
    tab[4] = '{7'd4, mk(1'b0, 2'd1, 36'h0F0F0F0F0, 16'h4444, 16'h0004, 16'h0040, 16'h0400), '0};
    tab[5] = '{7'd5, mk(1'b1, 2'd3, 36'h00000ABCD, 16'h5555, 16'hAAAA, 16'h5A5A, 16'hA5A5), '0};
    tab[6] = '{7'd6, mk(1'b0, 2'd2, 36'h600000006, 16'h0666, 16'h6660, 16'hF00F, 16'h0FF0), '0};
    tab[7] = '{7'd7, mk(1'b1, 2'd1, 36'h777777777, 16'h7777, 16'h0007, 16'h7000, 16'hC0DE), '0};
    for (int i = 0; i < 8; i++) tab[i].exp = tab[i].wdata;

    // Reset state
    step(); step();
    chk("rst_valid", 32'(m_vld), 32'd0);
    chk("rst_ready", 32'(m_rdy), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk_obj("rst_lane0", m_lane(0), '0);
    sys_rst_n = 1'b1;
    count_clear("init");

    // Idle read of index 5 on lane 0 returns the cleared entry
    set_rd(4'b0001, 7'd5);
    step(); idle(); step();
    chk("rd5_valid", 32'(m_vld), 32'h1);
    chk_obj("rd5_data", m_lane(0), '0);
    step();
    chk("rd5_pulse_end", 32'(m_vld), 32'h0);

    // Write index 3, read it back on all lanes the next cycle
    d = mk(1'b0, 2'd0, 36'h0, 16'h0120, 16'h0, 16'h0, 16'hFFE0);
    set_wr(7'd3, d);
    step(); idle(); set_rd(4'b1111, 7'd3);
    step(); idle(); step();
    chk("wr3_valid", 32'(m_vld), 32'hF);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("wr3_posx_l%0d", l), 32'(m_px[l]), 32'h0120);
      chk($sformatf("wr3_vely_l%0d", l), 32'(m_vy[l]), 32'hFFE0);
      chk_obj($sformatf("wr3_obj_l%0d", l), m_lane(l), d);
    end

    // Same-cycle write and read of index 7 on lane 2
    set_wr(7'd7, mk(1'b0, 2'd0, 36'h1, 16'h0, 16'h0, 16'h0, 16'h0));
    set_rd(4'b0100, 7'd7);
    step(); idle(); step();
`ifdef OBJ_TABLE_BYPASS_EN
    exp_prm = 36'h1;
`else
    exp_prm = 36'h0;
`endif
    chk("coll_valid", 32'(m_vld), 32'h4);
    chk("coll_params_lo", m_prm[2][31:0], exp_prm[31:0]);
    chk("coll_params_hi", 32'(m_prm[2][35:32]), 32'(exp_prm[35:32]));
    set_rd(4'b0100, 7'd7);
    step(); idle(); step();
    chk("coll_after_params", m_prm[2][31:0], 32'h1);

    // Table-driven writes 0..7, then lane 1 streams them back
    for (int i = 0; i < 8; i++) begin
      set_wr(tab[i].addr, tab[i].wdata);
      step();
    end
    idle();
    for (int s = 0; s < 10; s++) begin
      if (s < 8) begin
        read_valid_in = 4'b0010;
        load_addr_in[1] = tab[s].addr;
      end else begin
        read_valid_in = 4'b0000;
      end
      step();
      if (s >= 1 && s <= 8) begin
        chk($sformatf("strm_valid_%0d", s - 1), 32'(m_vld), 32'h2);
        chk_obj($sformatf("strm_data_%0d", s - 1), m_lane(1), tab[s - 1].exp);
      end else begin
        chk($sformatf("strm_idle_%0d", s), 32'(m_vld), 32'h0);
      end
    end
    step(); step();
    chk_obj("hold_lane1", m_lane(1), tab[7].exp);
    chk("hold_valid", 32'(m_vld), 32'h0);

    // Out-of-range write and read on the DEPTH=8 instance
    chk("small_err_before", 32'(s_err), 32'd0);
    set_wr(7'd9, mk(1'b1, 2'd3, 36'hABC, 16'h1234, 16'h0, 16'h0, 16'h0));
    set_rd(4'b0001, 7'd12);
    step(); idle(); step();
    chk("oor_valid", 32'(s_vld), 32'h1);
    chk_obj("oor_data", s_lane(0), '0);
    chk("oor_err", 32'(s_err), 32'd1);
    chk("main_err_clear", 32'(m_err), 32'd0);
    set_rd(4'b0001, 7'd1);
    step(); idle(); step();
    chk_obj("oor_no_alias", s_lane(0), tab[1].exp);
    repeat (5) step();
    chk("oor_err_sticky", 32'(s_err), 32'd1);

    // Reset asserted while reads on lanes 0 and 3 are in flight
    set_rd(4'b1001, 7'd3);
    step(); idle();
    sys_rst_n = 1'b0;
    #1;
    chk("inflt_valid", 32'(m_vld), 32'h0);
    chk("inflt_ready", 32'(m_rdy), 32'd0);
    chk("inflt_small_err", 32'(s_err), 32'd0);
    chk_obj("inflt_lane0", m_lane(0), '0);
    chk_obj("inflt_lane3", m_lane(3), '0);
    step();
    chk("inflt_valid_rst", 32'(m_vld), 32'h0);
    sys_rst_n = 1'b1;
    count_clear("reclr");
    set_rd(4'b0001, 7'd3);
    step(); idle(); step();
    chk("reclr_rd_valid", 32'(m_vld), 32'h1);
    chk_obj("reclr_rd_data", m_lane(0), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
